// File: rtl/conv3x3_engine_if.sv
// rtl/conv3x3_engine_if.sv - row-segment, kernel-write and result bundle for conv3x3_engine
//
// Purpose: groups the conv3x3_engine data and control signals.
// Ports (slave = engine side):
//   i_valid, i_pix0..i_pix2          row segment in (single-cycle qualifier)
//   i_coef_valid, i_coef_addr, i_coef kernel coefficient write
//   o_pixel, o_valid                 convolution result out
//   o_busy, o_frame_done             frame status
interface conv3x3_engine_if #(
  parameter int RAM_WIDTH  = 8,
  parameter int COEF_WIDTH = 8
);
  logic                         i_valid;
  logic [RAM_WIDTH-1:0]         i_pix0;
  logic [RAM_WIDTH-1:0]         i_pix1;
  logic [RAM_WIDTH-1:0]         i_pix2;
  logic                         i_coef_valid;
  logic [3:0]                   i_coef_addr;
  logic signed [COEF_WIDTH-1:0] i_coef;
  logic [RAM_WIDTH-1:0]         o_pixel;
  logic                         o_valid;
  logic                         o_busy;
  logic                         o_frame_done;

  modport slave (
    input  i_valid, i_pix0, i_pix1, i_pix2, i_coef_valid, i_coef_addr, i_coef,
    output o_pixel, o_valid, o_busy, o_frame_done
  );

  modport master (
    output i_valid, i_pix0, i_pix1, i_pix2, i_coef_valid, i_coef_addr, i_coef,
    input  o_pixel, o_valid, o_busy, o_frame_done
  );
endinterface

// File: rtl/conv3x3_engine.sv
// rtl/conv3x3_engine.sv - 3x3 signed-kernel convolution over column-strip row segments
//
// Purpose: builds a 3x3 window from 3-pixel row segments arriving top-to-bottom per
// vertical strip, convolves it with a programmable kernel and emits one saturated
// pixel per window position, two cycles after the segment completing the window.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    conv3x3_engine_if slave (segments/kernel writes in, results/status out)
module conv3x3_engine #(
  parameter int RAM_WIDTH    = 8,
  parameter int COEF_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10,
  parameter int SHIFT        = 4
) (
  input  logic             clk,
  input  logic             reset,
  conv3x3_engine_if.slave  bus
);
  localparam int PW      = RAM_WIDTH + COEF_WIDTH + 1;
  localparam int SUMW    = PW + 4;
  localparam int RCW     = $clog2(IMAGE_HEIGHT);
  localparam int SCW     = $clog2(IMAGE_WIDTH);
  localparam int PIX_MAX = (1 << RAM_WIDTH) - 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                       state_q, state_d;
  logic [RCW-1:0]               row_cnt_q, row_cnt_d;
  logic [SCW-1:0]               strip_cnt_q, strip_cnt_d;
  logic                         emit, emit_last;

  logic [RAM_WIDTH-1:0]         win_q [9];
  logic [RAM_WIDTH-1:0]         win_d [9];
  logic signed [COEF_WIDTH-1:0] coef_q [9];
  logic signed [PW-1:0]         prod_q [9];
  logic signed [PW-1:0]         prod_d [9];
  logic                         s1_valid_q, s1_last_q;

  logic signed [SUMW-1:0]       sum, shifted;
  logic [RAM_WIDTH-1:0]         sat;

  logic [RAM_WIDTH-1:0]         o_pixel_q;
  logic                         o_valid_q, o_frame_done_q;
  logic                         busy_q, busy_d;
  logic                         coef_we;

  // Row/strip sequencing; emit marks a segment that completes a window.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    strip_cnt_d = strip_cnt_q;
    emit        = 1'b0;
    emit_last   = 1'b0;
    if (bus.i_valid) begin
      case (state_q)
        IDLE: begin
          state_d     = FILL;
          row_cnt_d   = RCW'(1);
          strip_cnt_d = '0;
        end
        FILL: begin
          row_cnt_d = row_cnt_q + RCW'(1);
          if (row_cnt_q == RCW'(1)) state_d = RUN;
        end
        RUN: begin
          emit = 1'b1;
          if (row_cnt_q == RCW'(IMAGE_HEIGHT - 1)) begin
            row_cnt_d = '0;
            if (strip_cnt_q == SCW'(IMAGE_WIDTH - 3)) begin
              state_d     = IDLE;
              strip_cnt_d = '0;
              emit_last   = 1'b1;
            end else begin
              state_d     = FILL;
              strip_cnt_d = strip_cnt_q + SCW'(1);
            end
          end else begin
            row_cnt_d = row_cnt_q + RCW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Products are taken from the post-shift window so the incoming row is used directly.
  always_comb begin
    for (int k = 0; k < 6; k++) win_d[k] = win_q[k + 3];
    win_d[6] = bus.i_pix0;
    win_d[7] = bus.i_pix1;
    win_d[8] = bus.i_pix2;
    for (int k = 0; k < 9; k++)
      prod_d[k] = PW'($signed({1'b0, win_d[k]})) * PW'(coef_q[k]);
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < 9; k++) sum = sum + SUMW'(prod_q[k]);
    shifted = sum >>> SHIFT;
    if (shifted < 0)                          sat = '0;
    else if (shifted > $signed(SUMW'(PIX_MAX))) sat = '1;
    else                                      sat = shifted[RAM_WIDTH-1:0];
  end

  // A new frame may start while the previous one drains; the start wins over the clear.
  always_comb begin
    busy_d = busy_q;
    if (o_frame_done_q) busy_d = 1'b0;
    if (bus.i_valid && state_q == IDLE) busy_d = 1'b1;
  end

  assign coef_we = bus.i_coef_valid && state_q == IDLE && !bus.i_valid && !busy_q &&
                   bus.i_coef_addr <= 4'd8;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      row_cnt_q      <= '0;
      strip_cnt_q    <= '0;
      s1_valid_q     <= 1'b0;
      s1_last_q      <= 1'b0;
      o_pixel_q      <= '0;
      o_valid_q      <= 1'b0;
      o_frame_done_q <= 1'b0;
      busy_q         <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win_q[k]  <= '0;
        coef_q[k] <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      state_q        <= state_d;
      row_cnt_q      <= row_cnt_d;
      strip_cnt_q    <= strip_cnt_d;
      busy_q         <= busy_d;
      s1_valid_q     <= emit;
      s1_last_q      <= emit_last;
      o_valid_q      <= s1_valid_q;
      o_frame_done_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) o_pixel_q <= sat;
      if (bus.i_valid) begin
        for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
      end
      for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
      if (coef_we) coef_q[bus.i_coef_addr] <= bus.i_coef;
    end
  end

  assign bus.o_pixel      = o_pixel_q;
  assign bus.o_valid      = o_valid_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = o_frame_done_q;
endmodule

// File: tb/tb_conv3x3_engine.sv
// tb/tb_conv3x3_engine.sv - self-checking bench for conv3x3_engine
module tb_conv3x3_engine;
  localparam int W = 10;
  localparam int H = 10;
  localparam int SH = 4;
  localparam int NRES = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv3x3_engine_if #(.RAM_WIDTH(8), .COEF_WIDTH(8)) bus ();

  conv3x3_engine #(
    .RAM_WIDTH(8), .COEF_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .SHIFT(SH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int frame [H][W];
  int kern [9];
  int exp_q[$];
  int cap_pix[$];
  int cap_fd[$];
  int cap_busy[$];
  int cap_cyc[$];
  int comp_cyc[$];
  int busy_after_fd = -1;
  logic fd_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fd_prev) busy_after_fd = int'(bus.o_busy);
    fd_prev = bus.o_frame_done;
    if (bus.o_valid) begin
      cap_pix.push_back(int'(bus.o_pixel));
      cap_fd.push_back(int'(bus.o_frame_done));
      cap_busy.push_back(int'(bus.o_busy));
      cap_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: direct 3x3 dot product over the frame, then shift and clamp.
  function automatic int model_pix(int s, int r);
    int acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += kern[i*3 + j] * frame[r - 2 + i][s + j];
    acc = acc >>> SH;
    if (acc < 0) return 0;
    if (acc > 255) return 255;
    return acc;
  endfunction

  task automatic build_expected();
    for (int s = 0; s < W - 2; s++)
      for (int r = 2; r < H; r++)
        exp_q.push_back(model_pix(s, r));
  endtask

  task automatic clear_capture();
    cap_pix.delete(); cap_fd.delete(); cap_busy.delete(); cap_cyc.delete();
    comp_cyc.delete(); exp_q.delete(); busy_after_fd = -1;
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_coef(int addr, int val);
    bus.i_coef_addr  = 4'(addr);
    bus.i_coef       = 8'(val);
    bus.i_coef_valid = 1'b1;
    wait_cycles(1);
    bus.i_coef_valid = 1'b0;
  endtask

  task automatic load_kernel();
    for (int k = 0; k < 9; k++) write_coef(k, kern[k]);
  endtask

  task automatic set_identity();
    for (int k = 0; k < 9; k++) kern[k] = 0;
    kern[4] = 16;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = r * 10 + c;
  endtask

  task automatic fill_const(int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = v;
  endtask

  // Sends segments in strip order; stops after 'limit' segments when limit >= 0.
  task automatic send_frame(int maxgap, int limit);
    int sent = 0;
    for (int s = 0; s < W - 2; s++) begin
      for (int r = 0; r < H; r++) begin
        if (limit >= 0 && sent == limit) return;
        bus.i_pix0  = 8'(frame[r][s]);
        bus.i_pix1  = 8'(frame[r][s + 1]);
        bus.i_pix2  = 8'(frame[r][s + 2]);
        bus.i_valid = 1'b1;
        if (r >= 2) comp_cyc.push_back(cyc);
        wait_cycles(1);
        bus.i_valid = 1'b0;
        sent++;
        wait_cycles($urandom_range(0, maxgap));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_valid = 1'b0; bus.i_pix0 = '0; bus.i_pix1 = '0; bus.i_pix2 = '0;
    bus.i_coef_valid = 1'b0; bus.i_coef_addr = '0; bus.i_coef = '0;
    wait_cycles(3);
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_pixel !== 8'd0) begin n_err++; $display("FAIL reset_o_pixel got %0d want 0", bus.o_pixel); end
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_o_busy got %b want 0", bus.o_busy); end
    n_vec++; if (bus.o_frame_done !== 1'b0) begin n_err++; $display("FAIL reset_o_frame_done got %b want 0", bus.o_frame_done); end
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_identity();
    set_identity(); load_kernel(); fill_ramp(); clear_capture(); build_expected();
    send_frame(0, -1);
    wait_cycles(6);
    n_vec++; if (cap_pix.size() != NRES) begin n_err++; $display("FAIL ident_count got %0d want %0d", cap_pix.size(), NRES); end
    for (int i = 0; i < exp_q.size() && i < cap_pix.size(); i++) begin
      n_vec++; if (cap_pix[i] != exp_q[i]) begin n_err++; $display("FAIL ident_pix[%0d] got %0d want %0d", i, cap_pix[i], exp_q[i]); end
      n_vec++; if (cap_fd[i] != int'(i == NRES - 1)) begin n_err++; $display("FAIL ident_fd[%0d] got %0d want %0d", i, cap_fd[i], int'(i == NRES - 1)); end
      n_vec++; if (cap_cyc[i] != comp_cyc[i] + 2) begin n_err++; $display("FAIL ident_latency[%0d] got %0d want %0d", i, cap_cyc[i] - comp_cyc[i], 2); end
    end
    n_vec++; if (cap_pix.size() > 0 && cap_pix[0] != 11) begin n_err++; $display("FAIL ident_first got %0d want 11", cap_pix[0]); end
    n_vec++; if (cap_pix.size() > 7 && cap_pix[7] != 81) begin n_err++; $display("FAIL ident_strip0_end got %0d want 81", cap_pix[7]); end
    n_vec++; if (cap_pix.size() == NRES && cap_pix[NRES-1] != 88) begin n_err++; $display("FAIL ident_last got %0d want 88", cap_pix[NRES-1]); end
    n_vec++; if (cap_busy.size() == NRES && cap_busy[NRES-1] != 1) begin n_err++; $display("FAIL busy_at_done got %0d want 1", cap_busy[NRES-1]); end
    n_vec++; if (busy_after_fd != 0) begin n_err++; $display("FAIL busy_after_done got %0d want 0", busy_after_fd); end
  endtask

  task automatic test_saturation();
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 9; k++) kern[k] = (pass == 0) ? 16 : -1;
      load_kernel();
      fill_const((pass == 0) ? 200 : 50);
      clear_capture(); build_expected();
      send_frame(1, -1);
      wait_cycles(6);
      n_vec++; if (cap_pix.size() != NRES) begin n_err++; $display("FAIL sat%0d_count got %0d want %0d", pass, cap_pix.size(), NRES); end
      for (int i = 0; i < exp_q.size() && i < cap_pix.size(); i++) begin
        n_vec++; if (cap_pix[i] != exp_q[i]) begin n_err++; $display("FAIL sat%0d_pix[%0d] got %0d want %0d", pass, i, cap_pix[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_gaps(bit rand_data);
    if (rand_data) begin
      for (int k = 0; k < 9; k++) kern[k] = int'($urandom_range(0, 40)) - 20;
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) frame[r][c] = int'($urandom_range(0, 255));
    end else begin
      set_identity(); fill_ramp();
    end
    load_kernel(); clear_capture(); build_expected();
    send_frame(5, -1);
    wait_cycles(6);
    n_vec++; if (cap_pix.size() != NRES) begin n_err++; $display("FAIL gaps%0d_count got %0d want %0d", rand_data, cap_pix.size(), NRES); end
    for (int i = 0; i < exp_q.size() && i < cap_pix.size(); i++) begin
      n_vec++; if (cap_pix[i] != exp_q[i]) begin n_err++; $display("FAIL gaps%0d_pix[%0d] got %0d want %0d", rand_data, i, cap_pix[i], exp_q[i]); end
      n_vec++; if (cap_cyc[i] != comp_cyc[i] + 2) begin n_err++; $display("FAIL gaps%0d_latency[%0d] got %0d want 2", rand_data, i, cap_cyc[i] - comp_cyc[i]); end
    end
  endtask

  task automatic test_reset_mid();
    set_identity(); load_kernel(); fill_ramp(); clear_capture();
    send_frame(0, 30);
    reset = 1'b1;
    #1;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_o_valid got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL midrst_o_busy got %b want 0", bus.o_busy); end
    n_vec++; if (bus.o_pixel !== 8'd0) begin n_err++; $display("FAIL midrst_o_pixel got %0d want 0", bus.o_pixel); end
    cap_pix.delete();
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(6);
    n_vec++; if (cap_pix.size() != 0) begin n_err++; $display("FAIL midrst_stray_valid got %0d want 0", cap_pix.size()); end
    // Kernel was cleared by reset: a frame now gives all zeros.
    for (int k = 0; k < 9; k++) kern[k] = 0;
    clear_capture(); build_expected();
    send_frame(0, -1); wait_cycles(6);
    n_vec++; if (cap_pix.size() != NRES) begin n_err++; $display("FAIL midrst_zero_count got %0d want %0d", cap_pix.size(), NRES); end
    for (int i = 0; i < exp_q.size() && i < cap_pix.size(); i++) begin
      n_vec++; if (cap_pix[i] != exp_q[i]) begin n_err++; $display("FAIL midrst_zero_pix[%0d] got %0d want %0d", i, cap_pix[i], exp_q[i]); end
    end
    set_identity(); load_kernel(); clear_capture(); build_expected();
    send_frame(0, -1); wait_cycles(6);
    n_vec++; if (cap_pix.size() != NRES) begin n_err++; $display("FAIL midrst_fresh_count got %0d want %0d", cap_pix.size(), NRES); end
    for (int i = 0; i < exp_q.size() && i < cap_pix.size(); i++) begin
      n_vec++; if (cap_pix[i] != exp_q[i]) begin n_err++; $display("FAIL midrst_fresh_pix[%0d] got %0d want %0d", i, cap_pix[i], exp_q[i]); end
    end
  endtask

  task automatic test_coef_lock();
    set_identity(); load_kernel(); fill_ramp();
    for (int pass = 0; pass < 3; pass++) begin
      clear_capture();
      if (pass == 1) write_coef(12, 0);
      if (pass == 2) begin write_coef(4, 0); kern[4] = 0; end
      build_expected();
      if (pass == 0) begin
        fork
          send_frame(2, -1);
          repeat (12) begin wait_cycles(7); write_coef(4, 0); end
        join
      end else begin
        send_frame(0, -1);
      end
      wait_cycles(6);
      n_vec++; if (cap_pix.size() != NRES) begin n_err++; $display("FAIL lock%0d_count got %0d want %0d", pass, cap_pix.size(), NRES); end
      for (int i = 0; i < exp_q.size() && i < cap_pix.size(); i++) begin
        n_vec++; if (cap_pix[i] != exp_q[i]) begin n_err++; $display("FAIL lock%0d_pix[%0d] got %0d want %0d", pass, i, cap_pix[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    set_identity(); load_kernel(); fill_ramp(); clear_capture();
    build_expected(); build_expected();
    send_frame(0, -1);
    send_frame(0, -1);
    wait_cycles(6);
    n_vec++; if (cap_pix.size() != 2 * NRES) begin n_err++; $display("FAIL b2b_count got %0d want %0d", cap_pix.size(), 2 * NRES); end
    for (int i = 0; i < exp_q.size() && i < cap_pix.size(); i++) begin
      n_vec++; if (cap_pix[i] != exp_q[i]) begin n_err++; $display("FAIL b2b_pix[%0d] got %0d want %0d", i, cap_pix[i], exp_q[i]); end
      n_vec++; if (cap_fd[i] != int'(i == NRES - 1 || i == 2 * NRES - 1)) begin n_err++; $display("FAIL b2b_fd[%0d] got %0d", i, cap_fd[i]); end
      n_vec++; if (cap_cyc[i] != comp_cyc[i] + 2) begin n_err++; $display("FAIL b2b_latency[%0d] got %0d want 2", i, cap_cyc[i] - comp_cyc[i]); end
    end
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end got %b want 0", bus.o_busy); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_gaps(1'b0);
    test_gaps(1'b1);
    test_reset_mid();
    test_coef_lock();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
